// File: rtl/hazard_pkg.sv
// Shared types and constants for the load-use / branch hazard controller.
package hazard_pkg;

  typedef enum logic {
    HAZ_RUN   = 1'b0,
    HAZ_STALL = 1'b1
  } haz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int unsigned MAX_LOAD_STALL = 15;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ctrl_bubble;
    logic flush_ifid;
    logic flush_idex;
    logic flush_exmem;
  } haz_ctl_t;

  localparam haz_ctl_t CTL_RUN   = haz_ctl_t'(6'b110_000);
  localparam haz_ctl_t CTL_STALL = haz_ctl_t'(6'b001_000);
  localparam haz_ctl_t CTL_FLUSH = haz_ctl_t'(6'b110_111);

  function automatic int unsigned clamp_stall(input int unsigned n);
    if (n < 1)
      return 1;
    else if (n > MAX_LOAD_STALL)
      return MAX_LOAD_STALL;
    else
      return n;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare between ID/EX destination and IF/ID sources.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1IFID,
  input  logic [4:0] rs2IFID,
  input  logic       uses_rs1IFID,
  input  logic       uses_rs2IFID,
  input  logic [4:0] rdIDEX,
  input  logic       MemReadIDEX,
  output logic       hazard
);

  logic hit_rs1;
  logic hit_rs2;
  logic rd_live;

  assign hit_rs1 = uses_rs1IFID && (rdIDEX == rs1IFID);
  assign hit_rs2 = uses_rs2IFID && (rdIDEX == rs2IFID);
  assign rd_live = (rdIDEX != REG_X0);

  assign hazard = MemReadIDEX && rd_live && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller: load-use bubbles, taken-branch flushes and
// saturating event counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1IFID,
  input  logic [4:0]       rs2IFID,
  input  logic             uses_rs1IFID,
  input  logic             uses_rs2IFID,
  input  logic [4:0]       rdIDEX,
  input  logic             MemReadIDEX,
  input  logic             branch_takenEXMEM,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             ctrl_bubble,
  output logic             flushIFID,
  output logic             flushIDEX,
  output logic             flushEXMEM,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned LSC = clamp_stall(LOAD_STALL_CYCLES);
  localparam logic [3:0] CNT_RELOAD = 4'(LSC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  haz_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic     hazard;
  logic     stall;
  haz_ctl_t ctl;

  load_use_detect u_detect (
    .rs1IFID      (rs1IFID),
    .rs2IFID      (rs2IFID),
    .uses_rs1IFID (uses_rs1IFID),
    .uses_rs2IFID (uses_rs2IFID),
    .rdIDEX       (rdIDEX),
    .MemReadIDEX  (MemReadIDEX),
    .hazard       (hazard)
  );

  // A taken branch wins over both a fresh hazard and an ongoing stall.
  always_comb begin
    ctl     = CTL_RUN;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst) begin
      state_d = HAZ_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        HAZ_RUN: begin
          if (branch_takenEXMEM) begin
            ctl = CTL_FLUSH;
          end else if (hazard) begin
            ctl = CTL_STALL;
            if (LSC > 1) begin
              state_d = HAZ_STALL;
              cnt_d   = CNT_RELOAD;
            end
          end
        end
        HAZ_STALL: begin
          if (branch_takenEXMEM) begin
            ctl     = CTL_FLUSH;
            state_d = HAZ_RUN;
            cnt_d   = '0;
          end else begin
            ctl   = CTL_STALL;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1)
              state_d = HAZ_RUN;
          end
        end
        default: begin
          state_d = HAZ_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign stall = ~ctl.pc_write;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && (stall_cnt_q != CNT_MAX))
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (branch_takenEXMEM && (flush_cnt_q != CNT_MAX))
        flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HAZ_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PCWrite     = ctl.pc_write;
  assign IFIDWrite   = ctl.ifid_write;
  assign ctrl_bubble = ctl.ctrl_bubble;
  assign flushIFID   = ctl.flush_ifid;
  assign flushIDEX   = ctl.flush_idex;
  assign flushEXMEM  = ctl.flush_exmem;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: four parameterisations share one stimulus.
module tb_hazard_control_unit;

  localparam logic [5:0] C_RUN   = 6'b110_000;
  localparam logic [5:0] C_STALL = 6'b001_000;
  localparam logic [5:0] C_FLUSH = 6'b110_111;

  typedef struct {
    logic       r;
    logic [4:0] a1;
    logic [4:0] a2;
    logic       e1;
    logic       e2;
    logic [4:0] d;
    logic       m;
    logic       b;
    int         dut;
    logic [5:0] ctl;
    int         sc;
    int         fc;
    int         id;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0;
  logic [4:0] rs2 = '0;
  logic       u1 = 1'b0;
  logic       u2 = 1'b0;
  logic [4:0] rd = '0;
  logic       mr = 1'b0;
  logic       br = 1'b0;

  logic [5:0]  ctl_a [4];
  logic [15:0] sc_a [4];
  logic [15:0] fc_a [4];
  logic [3:0]  sc3;
  logic [3:0]  fc3;

  vec_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_vec = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .rs1IFID(rs1), .rs2IFID(rs2),
    .uses_rs1IFID(u1), .uses_rs2IFID(u2), .rdIDEX(rd),
    .MemReadIDEX(mr), .branch_takenEXMEM(br),
    .PCWrite(ctl_a[0][5]), .IFIDWrite(ctl_a[0][4]),
    .ctrl_bubble(ctl_a[0][3]), .flushIFID(ctl_a[0][2]),
    .flushIDEX(ctl_a[0][1]), .flushEXMEM(ctl_a[0][0]),
    .stall_count(sc_a[0]), .flush_count(fc_a[0])
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .rs1IFID(rs1), .rs2IFID(rs2),
    .uses_rs1IFID(u1), .uses_rs2IFID(u2), .rdIDEX(rd),
    .MemReadIDEX(mr), .branch_takenEXMEM(br),
    .PCWrite(ctl_a[1][5]), .IFIDWrite(ctl_a[1][4]),
    .ctrl_bubble(ctl_a[1][3]), .flushIFID(ctl_a[1][2]),
    .flushIDEX(ctl_a[1][1]), .flushEXMEM(ctl_a[1][0]),
    .stall_count(sc_a[1]), .flush_count(fc_a[1])
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(4), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .rs1IFID(rs1), .rs2IFID(rs2),
    .uses_rs1IFID(u1), .uses_rs2IFID(u2), .rdIDEX(rd),
    .MemReadIDEX(mr), .branch_takenEXMEM(br),
    .PCWrite(ctl_a[2][5]), .IFIDWrite(ctl_a[2][4]),
    .ctrl_bubble(ctl_a[2][3]), .flushIFID(ctl_a[2][2]),
    .flushIDEX(ctl_a[2][1]), .flushEXMEM(ctl_a[2][0]),
    .stall_count(sc_a[2]), .flush_count(fc_a[2])
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(15), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .rs1IFID(rs1), .rs2IFID(rs2),
    .uses_rs1IFID(u1), .uses_rs2IFID(u2), .rdIDEX(rd),
    .MemReadIDEX(mr), .branch_takenEXMEM(br),
    .PCWrite(ctl_a[3][5]), .IFIDWrite(ctl_a[3][4]),
    .ctrl_bubble(ctl_a[3][3]), .flushIFID(ctl_a[3][2]),
    .flushIDEX(ctl_a[3][1]), .flushEXMEM(ctl_a[3][0]),
    .stall_count(sc3), .flush_count(fc3)
  );

  assign sc_a[3] = {12'b0, sc3};
  assign fc_a[3] = {12'b0, fc3};

  // Scoreboard: outputs are combinational, so compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      vec_t e;
      e = q.pop_front();
      n_chk = n_chk + 3;
      if (ctl_a[e.dut] !== e.ctl) begin
        n_fail++;
        $display("FAIL ctl dut%0d vec%0d: got %b want %b",
                 e.dut, e.id, ctl_a[e.dut], e.ctl);
      end
      if (sc_a[e.dut] !== 16'(e.sc)) begin
        n_fail++;
        $display("FAIL stall_count dut%0d vec%0d: got %0d want %0d",
                 e.dut, e.id, sc_a[e.dut], e.sc);
      end
      if (fc_a[e.dut] !== 16'(e.fc)) begin
        n_fail++;
        $display("FAIL flush_count dut%0d vec%0d: got %0d want %0d",
                 e.dut, e.id, fc_a[e.dut], e.fc);
      end
    end
  end

  task automatic apply(input vec_t v);
    vec_t e;
    e = v;
    e.id = n_vec;
    n_vec++;
    rst = v.r; rs1 = v.a1; rs2 = v.a2;
    u1 = v.e1; u2 = v.e2; rd = v.d;
    mr = v.m; br = v.b;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic hz, input logic b,
                      input int dut, input logic [5:0] ctl,
                      input int sc, input int fc);
    vec_t v;
    v = '{r, 5'd5, 5'd0, hz, 1'b0, 5'd5, hz, b,
          dut, ctl, sc, fc, 0};
    apply(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; rs1 = '0; rs2 = '0; u1 = 0; u2 = 0;
    rd = '0; mr = 0; br = 0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1, 5, 0, 1, 0, 5, 1, 0, 0, C_RUN,   0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, C_RUN,   0, 0, 0};
    tbl[2]  = '{0, 0, 7, 0, 0, 7, 1, 0, 0, C_RUN,   0, 0, 0};
    tbl[3]  = '{0, 0, 7, 0, 1, 7, 0, 0, 0, C_RUN,   0, 0, 0};
    tbl[4]  = '{0, 5, 0, 1, 0, 5, 1, 0, 0, C_STALL, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   1, 0, 0};
    tbl[6]  = '{0, 3, 9, 1, 1, 9, 1, 0, 0, C_STALL, 1, 0, 0};
    tbl[7]  = '{0, 3, 9, 1, 1, 9, 1, 0, 0, C_STALL, 2, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 0, 0};
    tbl[9]  = '{0, 5, 0, 1, 0, 5, 1, 1, 0, C_FLUSH, 3, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, C_FLUSH, 3, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   3, 2, 0};

    do_reset();
    for (int i = 0; i < 13; i++)
      apply(tbl[i]);

    // three-cycle stall, then branch discarding a hazard, then back-to-back
    do_reset();
    step(0, 1, 0, 1, C_STALL, 0, 0);
    step(0, 0, 0, 1, C_STALL, 1, 0);
    step(0, 0, 0, 1, C_STALL, 2, 0);
    step(0, 0, 0, 1, C_RUN,   3, 0);
    do_reset();
    step(0, 1, 1, 1, C_FLUSH, 0, 0);
    step(0, 0, 0, 1, C_RUN,   0, 1);
    step(0, 1, 0, 1, C_STALL, 0, 1);
    step(0, 0, 0, 1, C_STALL, 1, 1);
    step(0, 1, 0, 1, C_STALL, 2, 1);
    step(0, 1, 0, 1, C_STALL, 3, 1);
    step(0, 0, 0, 1, C_STALL, 4, 1);
    step(0, 0, 0, 1, C_STALL, 5, 1);
    step(0, 0, 0, 1, C_RUN,   6, 1);

    // reset on the 2nd stall cycle, then branch on the 3rd stall cycle
    do_reset();
    step(0, 1, 0, 2, C_STALL, 0, 0);
    step(1, 0, 0, 2, C_RUN,   1, 0);
    step(0, 0, 0, 2, C_RUN,   0, 0);
    step(0, 0, 0, 2, C_RUN,   0, 0);
    step(0, 1, 0, 2, C_STALL, 0, 0);
    step(0, 0, 0, 2, C_STALL, 1, 0);
    step(0, 0, 1, 2, C_FLUSH, 2, 0);
    step(0, 0, 0, 2, C_RUN,   2, 1);
    step(0, 0, 0, 2, C_RUN,   2, 1);

    // 4-bit counters saturate at 15
    do_reset();
    for (int k = 0; k < 30; k++) begin
      int exp_sc;
      exp_sc = (k > 15) ? 15 : k;
      step(0, (k == 0 || k == 15), 0, 3, C_STALL, exp_sc, 0);
    end
    step(0, 0, 0, 3, C_RUN, 15, 0);
    for (int j = 0; j < 17; j++) begin
      int exp_fc;
      exp_fc = (j > 15) ? 15 : j;
      step(0, 0, 1, 3, C_FLUSH, 15, exp_fc);
    end
    step(0, 0, 0, 3, C_RUN, 15, 15);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
